pwm_multi_channel: RTL

//  NUM_CH-channel PWM generator with a shared period counter and per-channel duty

---
 rtl/pwm_pkg.sv | 17 +
 rtl/btn_debounce.sv | 25 ++
 rtl/pwm_multi_channel.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM block.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Width of a selector over n items, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Samples a raw button on each debounce tick and emits a one-clock pulse per rising edge.
module btn_debounce (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic tick,
  output logic press
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (tick) begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  assign press = s1 & ~s2 & tick;

endmodule

// File: rtl/pwm_multi_channel.sv
// NUM_CH-channel PWM with a shared edge/centre-aligned counter and button-driven duty
// registers that are shadowed into the compare stage only at frame boundaries.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int PERIOD    = 10,
  parameter int CNT_W     = 8,
  parameter int STEP      = 1,
  parameter int DUTY_INIT = 5,
  parameter int DEB_DIV   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         mode,
  input  logic                         btn_inc,
  input  logic                         btn_dec,
  input  logic [sel_width(NUM_CH)-1:0] ch_sel,
  output logic [NUM_CH-1:0]            pwm_out,
  output logic [CNT_W-1:0]             duty_q,
  output logic                         period_tick
);

  localparam int               SEL_W  = sel_width(NUM_CH);
  localparam int               DIV_W  = sel_width(DEB_DIV);
  localparam logic [CNT_W-1:0] TOP    = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] INIT_C = CNT_W'(DUTY_INIT);

  logic [DIV_W-1:0] div;
  logic             tick;
  logic             inc_press;
  logic             dec_press;
  logic [CNT_W-1:0] cnt;
  dir_t             dir;
  logic             mode_act;
  logic             boundary;
  logic             shadow_load;
  logic [CNT_W-1:0] duty_pend [NUM_CH];
  logic [CNT_W-1:0] duty_act  [NUM_CH];

  // Duty is kept within 0..PERIOD, so the subtraction below cannot underflow.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] d);
    return (d >= FULL - STEP_C) ? FULL : d + STEP_C;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] d);
    return (d <= STEP_C) ? '0 : d - STEP_C;
  endfunction

  assign tick = (div == DIV_W'(DEB_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

  btn_debounce u_deb_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_inc),
    .tick  (tick),
    .press (inc_press)
  );

  btn_debounce u_deb_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_dec),
    .tick  (tick),
    .press (dec_press)
  );

  assign boundary    = (mode_act == MODE_EDGE) ? (cnt == TOP)
                                               : (dir == DIR_DOWN && cnt == '0);
  assign shadow_load = !en || boundary;

  // Both boundary paths leave dir at DIR_UP, so a mode change always starts a clean up-count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      dir         <= DIR_UP;
      mode_act    <= MODE_EDGE;
      period_tick <= 1'b0;
    end else begin
      period_tick <= en & boundary;
      if (shadow_load) mode_act <= mode;
      if (!en) begin
        cnt <= '0;
        dir <= DIR_UP;
      end else if (mode_act == MODE_EDGE) begin
        dir <= DIR_UP;
        cnt <= boundary ? '0 : cnt + 1'b1;
      end else if (dir == DIR_UP) begin
        if (cnt == TOP) dir <= DIR_DOWN;
        else            cnt <= cnt + 1'b1;
      end else begin
        if (cnt == '0)  dir <= DIR_UP;
        else            cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        duty_pend[i] <= INIT_C;
        duty_act[i]  <= INIT_C;
      end
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_sel == SEL_W'(i)) begin
          if (inc_press && !dec_press)      duty_pend[i] <= sat_inc(duty_pend[i]);
          else if (dec_press && !inc_press) duty_pend[i] <= sat_dec(duty_pend[i]);
        end
        if (shadow_load) duty_act[i] <= duty_pend[i];
        pwm_out[i] <= en & (cnt < duty_act[i]);
      end
    end
  end

  // Out-of-range selections match no channel and read back as zero.
  always_comb begin
    duty_q = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == SEL_W'(i)) duty_q = duty_pend[i];
    end
  end

endmodule
